// File: rtl/wb_regbank_arbiter.sv
// Register bank in the Caravel user Wishbone window, shared between the
// Wishbone slave port and a local user-logic port by round-robin arbitration.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting; the winning access is committed on the edge leaving
// ST_WB_ACK  | Wishbone access done, wbs_ack_o high for this cycle
// ST_LOC_ACK | local access done, loc_gnt_o high for this cycle
module wb_regbank_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_REGS  = 4
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_ni,
  input  logic                             wbs_stb_i,
  input  logic                             wbs_cyc_i,
  input  logic                             wbs_we_i,
  input  logic [3:0]                       wbs_sel_i,
  input  logic [31:0]                      wbs_dat_i,
  input  logic [31:0]                      wbs_adr_i,
  output logic                             wbs_ack_o,
  output logic [31:0]                      wbs_dat_o,
  input  logic                             loc_req_i,
  input  logic                             loc_we_i,
  input  logic [$clog2(NUM_REGS)-1:0]      loc_idx_i,
  input  logic [31:0]                      loc_dat_i,
  output logic                             loc_gnt_o,
  output logic [31:0]                      loc_dat_o,
  output logic [32*NUM_REGS-1:0]           reg_q_o
);

  localparam int IDXW = $clog2(NUM_REGS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WB_ACK  = 2'd1;
  localparam logic [1:0] ST_LOC_ACK = 2'd2;

  logic [1:0]      state;
  logic            last_loc;   // 1: local side was granted last, so WB wins a tie
  logic [31:0]     regs [NUM_REGS];
  logic            wb_hit;
  logic [IDXW-1:0] wb_idx;
  logic            idle;
  logic            grant_wb;
  logic            grant_loc;

  // Byte-offset bits play no part in word addressing.
  logic unused_adr_lsb;
  assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

  assign wb_hit = wbs_stb_i & wbs_cyc_i &
                  (wbs_adr_i[31:2+IDXW] == BASE_ADDR[31:2+IDXW]);
  assign wb_idx = wbs_adr_i[2+IDXW-1:2];
  assign idle   = (state == ST_IDLE);

  // Round-robin choice between the two requesters while idle.
  always_comb begin
    grant_wb  = idle & wb_hit & (~loc_req_i | last_loc);
    grant_loc = idle & loc_req_i & (~wb_hit | ~last_loc);
  end

  // Ack/grant come straight from state so reset removes them immediately.
  assign wbs_ack_o = (state == ST_WB_ACK);
  assign loc_gnt_o = (state == ST_LOC_ACK);

  // Slot sequencing and arbitration history.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= ST_IDLE;
      last_loc <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_wb) begin
            state    <= ST_WB_ACK;
            last_loc <= 1'b0;
          end else if (grant_loc) begin
            state    <= ST_LOC_ACK;
            last_loc <= 1'b1;
          end
        end
        ST_WB_ACK:  state <= ST_IDLE;
        ST_LOC_ACK: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Register writes: WB honours byte lanes, local writes the full word.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (grant_wb && wbs_we_i) begin
      for (int b = 0; b < 4; b++)
        if (wbs_sel_i[b]) regs[wb_idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
    end else if (grant_loc && loc_we_i) begin
      regs[loc_idx_i] <= loc_dat_i;
    end
  end

  // Read data capture; held until the next read on the same port.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_dat_o <= '0;
      loc_dat_o <= '0;
    end else begin
      if (grant_wb && !wbs_we_i)   wbs_dat_o <= regs[wb_idx];
      if (grant_loc && !loc_we_i)  loc_dat_o <= regs[loc_idx_i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q_o[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_wb_regbank_arbiter.sv
// Bench for wb_regbank_arbiter: directed scenarios followed by randomized
// traffic from both requesters, checked against a transaction-level model.
module tb_wb_regbank_arbiter;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          NR   = 4;

  logic        clk;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr;
  logic        ack;
  logic [31:0] wb_rdat;
  logic        lreq, lwe;
  logic [1:0]  lidx;
  logic [31:0] ldat;
  logic        gnt;
  logic [31:0] loc_rdat;
  logic [32*NR-1:0] reg_q;

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] m_regs [NR];
  logic [31:0] m_wdat, m_ldat;
  bit          m_last_wb;
  bit          m_busy;

  wb_regbank_arbiter #(.BASE_ADDR(BASE), .NUM_REGS(NR)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(wb_rdat),
    .loc_req_i(lreq), .loc_we_i(lwe), .loc_idx_i(lidx), .loc_dat_i(ldat),
    .loc_gnt_o(gnt), .loc_dat_o(loc_rdat), .reg_q_o(reg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * NR));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_wdat = '0; m_ldat = '0;
    m_last_wb = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic check_all();
    for (int i = 0; i < NR; i++) check($sformatf("reg%0d", i), reg_q[32*i +: 32], m_regs[i]);
    check("wbs_dat", wb_rdat, m_wdat);
    check("loc_dat", loc_rdat, m_ldat);
  endtask

  // One clock: predict the winner from the current inputs, advance, compare.
  task automatic tick(output bit gw, output bit gl);
    bit hit;
    int idx;
    hit = stb && cyc && in_window(adr);
    gw = 1'b0; gl = 1'b0;
    if (!m_busy) begin
      if (hit && lreq) begin
        if (m_last_wb) gl = 1'b1; else gw = 1'b1;
      end else begin
        gw = hit; gl = lreq;
      end
    end
    if (gw) begin
      idx = int'((adr - BASE) / 4);
      if (we) begin
        for (int b = 0; b < 4; b++) if (sel[b]) m_regs[idx][8*b +: 8] = wdat[8*b +: 8];
      end else m_wdat = m_regs[idx];
      m_last_wb = 1'b1;
    end
    if (gl) begin
      if (lwe) m_regs[lidx] = ldat; else m_ldat = m_regs[lidx];
      m_last_wb = 1'b0;
    end
    m_busy = gw | gl;
    @(posedge clk); #1;
    check("wbs_ack", 32'(ack), 32'(gw));
    check("loc_gnt", 32'(gnt), 32'(gl));
    check_all();
  endtask

  task automatic wb_set(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    stb = 1'b1; cyc = 1'b1; adr = a; we = w; sel = s; wdat = d;
  endtask

  task automatic wb_clr();
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic loc_set(input logic w, input logic [1:0] i, input logic [31:0] d);
    lreq = 1'b1; lwe = w; lidx = i; ldat = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    bit gw, gl, wb_pend, loc_pend;
    rst_n = 1'b0;
    wb_clr(); adr = '0; wdat = '0;
    lreq = 1'b0; lwe = 1'b0; lidx = '0; ldat = '0;
    model_reset();
    #12;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check_all();
    @(negedge clk); rst_n = 1'b1;

    // WB full write and read-back at BASE+4
    wb_set(BASE + 4, 1'b1, 4'hF, 32'hDEADBEEF);
    tick(gw, gl);
    check("t2_ack", 32'(ack), 32'd1);
    check("t2_reg1", reg_q[63:32], 32'hDEADBEEF);
    wb_clr(); tick(gw, gl);
    wb_set(BASE + 4, 1'b0, 4'hF, 32'h0);
    tick(gw, gl);
    check("t2_rdat", wb_rdat, 32'hDEADBEEF);
    wb_clr(); tick(gw, gl);

    // byte lanes
    wb_set(BASE, 1'b1, 4'hF, 32'h11223344); tick(gw, gl);
    wb_clr(); tick(gw, gl);
    wb_set(BASE, 1'b1, 4'b0101, 32'hAABBCCDD); tick(gw, gl);
    check("t3_reg0", reg_q[31:0], 32'h11BB33DD);
    wb_clr(); tick(gw, gl);
    wb_set(BASE + 8, 1'b1, 4'h0, 32'hFFFFFFFF); tick(gw, gl);
    wb_clr(); tick(gw, gl);

    // out-of-window accesses
    wb_set(BASE + 32'(4 * NR), 1'b1, 4'hF, 32'h12345678); tick(gw, gl); tick(gw, gl);
    wb_set(32'h2FFF_FFFC, 1'b1, 4'hF, 32'h87654321); tick(gw, gl); tick(gw, gl);
    wb_clr(); tick(gw, gl);

    // reset in the middle of an ack cycle
    wb_set(BASE + 12, 1'b1, 4'hF, 32'hCAFEF00D);
    tick(gw, gl);
    #2;
    wb_clr();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t1_ack_drop", 32'(ack), 32'd0);
    check_all();
    rst_n = 1'b1;
    tick(gw, gl);

    // tie after reset, both held: WB, idle, LOC, idle, WB ...
    wb_set(BASE + 8, 1'b0, 4'hF, 32'h0);
    loc_set(1'b0, 2'd0, 32'h0);
    tick(gw, gl); check("t4_first_wb", 32'(ack), 32'd1);
    tick(gw, gl);
    tick(gw, gl); check("t4_then_loc", 32'(gnt), 32'd1);
    tick(gw, gl); tick(gw, gl); tick(gw, gl); tick(gw, gl);
    wb_clr(); lreq = 1'b0; tick(gw, gl);

    // simultaneous writes to reg3 after reset: local lands last
    do_reset();
    @(posedge clk); #1;
    wb_set(BASE + 12, 1'b1, 4'hF, 32'h1);
    loc_set(1'b1, 2'd3, 32'h5A5A0001);
    tick(gw, gl); wb_clr();
    tick(gw, gl);
    tick(gw, gl); lreq = 1'b0;
    tick(gw, gl);
    check("t5_reg3", reg_q[127:96], 32'h5A5A0001);

    // randomized traffic from both sides, each holding until served
    wb_pend = 1'b0; loc_pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!wb_pend && $urandom_range(0, 2) != 0) begin
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r < 8)       a = BASE + 32'(4 * $urandom_range(0, NR - 1)) + 32'($urandom_range(0, 3));
        else if (r == 8) a = BASE + 32'(4 * NR);
        else             a = 32'h2FFF_FFFC;
        wb_set(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        wb_pend = 1'b1;
      end
      if (!loc_pend && $urandom_range(0, 2) != 0) begin
        loc_set(1'($urandom_range(0, 1)), 2'($urandom_range(0, NR - 1)), $urandom);
        loc_pend = 1'b1;
      end
      tick(gw, gl);
      if (wb_pend && (gw || !in_window(adr))) begin
        wb_pend = 1'b0;
        if ($urandom_range(0, 1) == 0) wb_clr();
      end
      if (!wb_pend) wb_clr();
      if (gl) begin
        loc_pend = 1'b0;
        lreq = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
